// File: rtl/risc_seq_ctrl_if.sv
// Shared memory port of the SISC sequencer: req/ack handshake with address,
// write-enable and write-data select; read data returns with the ack.
interface risc_seq_ctrl_if #(
  parameter int ADDRSIZE = 12
);
  logic                mem_req;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [1:0]          mem_wsel;
  logic                mem_ack;
  logic [31:0]         mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wsel,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wsel,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle fetch/execute/writeback sequencer for the 32-bit SISC core.
// Optional RISC_ILLEGAL_HALT_EN: illegal opcodes halt instead of acting as NOP.
module risc_seq_ctrl #(
  parameter int ADDRSIZE = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  risc_seq_ctrl_if.master      mbus,
  input  logic [4:0]           psr_in,
  output logic                 alu_start,
  input  logic                 alu_done,
  output logic                 rf_we,
  output logic                 rf_wsel,
  output logic                 psr_we,
  output logic [ADDRSIZE-1:0]  pc,
  output logic [31:0]          ir,
  output logic                 halted,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEMRD, S_MEMWR, S_ALUWAIT, S_WRB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_BRA = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_STR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_SHF = 4'd7;
  localparam logic [3:0] OP_ROT = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd9;

  state_t              state, state_n;
  logic [ADDRSIZE-1:0] pc_n;
  logic [31:0]         ir_n;
  logic                illegal_n;
  logic                br_taken;

  logic [3:0]          op;
  logic [ADDRSIZE-1:0] src_addr, dst_addr;

  assign op       = ir[31:28];
  assign src_addr = ir[12 +: ADDRSIZE];
  assign dst_addr = ir[0 +: ADDRSIZE];

  // psr_in is {NEG,ZERO,PARITY,EVEN,CARRY}; codes 6-15 never branch
  always_comb begin
    br_taken = 1'b0;
    case (ir[27:24])
      4'd0:    br_taken = 1'b1;
      4'd1:    br_taken = psr_in[0];
      4'd2:    br_taken = psr_in[1];
      4'd3:    br_taken = psr_in[2];
      4'd4:    br_taken = psr_in[3];
      4'd5:    br_taken = psr_in[4];
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      ir      <= ir_n;
      illegal <= illegal_n;
    end
  end

  // Bus outputs decode straight from state so an async reset drops mem_req at once
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    ir_n           = ir;
    illegal_n      = illegal;
    mbus.mem_req   = 1'b0;
    mbus.mem_we    = 1'b0;
    mbus.mem_addr  = '0;
    mbus.mem_wsel  = 2'd0;
    alu_start      = 1'b0;
    rf_we          = 1'b0;
    rf_wsel        = 1'b0;
    psr_we         = 1'b0;
    halted         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
        end
      end

      S_FETCH: begin
        mbus.mem_req  = 1'b1;
        mbus.mem_addr = pc;
        if (mbus.mem_ack) begin
          ir_n    = mbus.mem_rdata;
          pc_n    = pc + 1'b1;
          state_n = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_NOP: state_n = S_FETCH;
          OP_BRA: begin
            if (br_taken) pc_n = dst_addr;
            state_n = S_FETCH;
          end
          OP_LD: begin
            if (ir[27]) begin
              rf_we   = 1'b1;
              rf_wsel = 1'b1;
              psr_we  = 1'b1;
              state_n = S_FETCH;
            end else begin
              state_n = S_MEMRD;
            end
          end
          OP_STR: state_n = S_MEMWR;
          OP_ADD, OP_MUL, OP_CMP, OP_SHF, OP_ROT: begin
            alu_start = 1'b1;
            state_n   = S_ALUWAIT;
          end
          OP_HLT: state_n = S_HALT;
          default: begin
            illegal_n = 1'b1;
`ifdef RISC_ILLEGAL_HALT_EN
            state_n   = S_HALT;
`else
            state_n   = S_FETCH;
`endif
          end
        endcase
      end

      S_MEMRD: begin
        mbus.mem_req  = 1'b1;
        mbus.mem_addr = src_addr;
        if (mbus.mem_ack) begin
          rf_we   = 1'b1;
          psr_we  = 1'b1;
          state_n = S_FETCH;
        end
      end

      S_MEMWR: begin
        mbus.mem_req  = 1'b1;
        mbus.mem_we   = 1'b1;
        mbus.mem_addr = dst_addr;
        mbus.mem_wsel = {1'b0, ir[27]};
        if (mbus.mem_ack) begin
          psr_we  = 1'b1;
          state_n = S_FETCH;
        end
      end

      S_ALUWAIT: begin
        if (alu_done) begin
          psr_we = 1'b1;
          if (!ir[26]) begin
            rf_we   = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WRB;
          end
        end
      end

      S_WRB: begin
        mbus.mem_req  = 1'b1;
        mbus.mem_we   = 1'b1;
        mbus.mem_addr = dst_addr;
        mbus.mem_wsel = 2'd2;
        if (mbus.mem_ack) state_n = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) state_n = S_FETCH;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Directed bench for risc_seq_ctrl: small memory with programmable ack delay,
// ALU with programmable done delay, and event counters on the strobes.
module tb_risc_seq_ctrl;
  localparam int AW = 12;
  localparam logic [31:0] HLT = 32'h9000_0000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    psr_in = 5'd0;
  logic          alu_start, alu_done, rf_we, rf_wsel, psr_we, halted, illegal;
  logic [AW-1:0] pc;
  logic [31:0]   ir;

  int checks = 0;
  int failures = 0;

  risc_seq_ctrl_if #(.ADDRSIZE(AW)) mbus();

  risc_seq_ctrl #(.ADDRSIZE(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mbus(mbus),
    .psr_in(psr_in), .alu_start(alu_start), .alu_done(alu_done),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .psr_we(psr_we),
    .pc(pc), .ir(ir), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // memory model: ack after ack_dly wait cycles, never for a read of stall_addr
  logic [31:0] mem [0:4095];
  int ack_dly = 0;
  int alu_dly = 1;
  int stall_addr = -1;
  int wait_cnt;
  int alu_cnt;
  logic alu_busy;

  assign mbus.mem_rdata = mem[mbus.mem_addr];
  assign mbus.mem_ack = mbus.mem_req && (mbus.mem_we || int'(mbus.mem_addr) != stall_addr)
                        && (wait_cnt == ack_dly);

  always @(posedge clk or negedge reset_n)
    if (!reset_n) wait_cnt <= 0;
    else if (mbus.mem_req && !mbus.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      alu_busy <= 1'b0; alu_cnt <= 0;
    end else if (alu_start) begin
      alu_busy <= 1'b1; alu_cnt <= 1;
    end else if (alu_done) alu_busy <= 1'b0;
    else if (alu_busy) alu_cnt <= alu_cnt + 1;

  assign alu_done = alu_busy && (alu_cnt == alu_dly);

  // strobe monitors, sampled on the edge where the datapath would
  int n_alu = 0, n_rf = 0, n_psr = 0, n_rd = 0, n_wr = 0, n_wr_cyc = 0;
  logic last_rf_wsel = 0, last_psr_ack = 0, last_psr_done = 0;
  logic [AW-1:0] last_waddr = '0, rd_last = '0, rd_prev = '0;
  logic [1:0] last_wsel = 2'd0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (alu_start) n_alu <= n_alu + 1;
      if (rf_we) begin n_rf <= n_rf + 1; last_rf_wsel <= rf_wsel; end
      if (psr_we) begin
        n_psr <= n_psr + 1;
        last_psr_ack <= mbus.mem_ack;
        last_psr_done <= alu_done;
      end
      if (mbus.mem_req && mbus.mem_we) n_wr_cyc <= n_wr_cyc + 1;
      if (mbus.mem_req && mbus.mem_we && mbus.mem_ack) begin
        n_wr <= n_wr + 1; last_waddr <= mbus.mem_addr; last_wsel <= mbus.mem_wsel;
      end
      if (mbus.mem_req && !mbus.mem_we && mbus.mem_ack) begin
        n_rd <= n_rd + 1; rd_prev <= rd_last; rd_last <= mbus.mem_addr;
      end
    end
  end

  task automatic run_prog(input int bound, output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!halted) cyc = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mbus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mbus.mem_req); end
    checks++; if (mbus.mem_addr !== '0 || mbus.mem_we !== 1'b0 || mbus.mem_wsel !== 2'd0) begin
      failures++; $display("FAIL reset_bus got addr=%h we=%b wsel=%0d exp 0/0/0", mbus.mem_addr, mbus.mem_we, mbus.mem_wsel); end
    checks++; if (pc !== '0 || ir !== 32'd0) begin failures++; $display("FAIL reset_pc_ir got pc=%h ir=%h exp 0", pc, ir); end
    checks++; if ({halted, illegal, alu_start, rf_we, psr_we, rf_wsel} !== 6'd0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {halted, illegal, alu_start, rf_we, psr_we, rf_wsel}); end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mbus.mem_req !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL idle_wait got req=%b halted=%b exp 0/0", mbus.mem_req, halted); end
  endtask

  task automatic test_nop_hlt();
    int cyc, rd0;
    mem[0] = 32'h0000_0000;
    mem[1] = HLT;
    rd0 = n_rd;
    run_prog(20, cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL nop_hlt_cycles got=%0d exp=4", cyc); end
    checks++; if (pc !== 12'h002) begin failures++; $display("FAIL nop_hlt_pc got=%h exp=002", pc); end
    checks++; if (n_rd - rd0 != 2 || rd_prev !== 12'h000 || rd_last !== 12'h001) begin
      failures++; $display("FAIL nop_hlt_fetch got n=%0d %h,%h exp 2 000,001", n_rd - rd0, rd_prev, rd_last); end
  endtask

  task automatic test_ld_imm();
    int cyc, rd0, rf0, ps0, wr0;
    mem[2] = 32'h2800_5003;
    mem[3] = HLT;
    rd0 = n_rd; rf0 = n_rf; ps0 = n_psr; wr0 = n_wr;
    run_prog(20, cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL ld_imm_cycles got=%0d exp=4", cyc); end
    checks++; if (n_rf - rf0 != 1 || last_rf_wsel !== 1'b1) begin
      failures++; $display("FAIL ld_imm_rf got n=%0d wsel=%b exp 1/1", n_rf - rf0, last_rf_wsel); end
    checks++; if (n_psr - ps0 != 1) begin failures++; $display("FAIL ld_imm_psr got=%0d exp=1", n_psr - ps0); end
    checks++; if (n_rd - rd0 != 2 || n_wr != wr0) begin
      failures++; $display("FAIL ld_imm_mem got rd=%0d wr=%0d exp 2/0", n_rd - rd0, n_wr - wr0); end
  endtask

  task automatic test_str_delayed();
    int cyc, wr0, wc0, ps0, rf0;
    mem[4] = 32'h3001_0040;
    mem[5] = HLT;
    ack_dly = 3;
    wr0 = n_wr; wc0 = n_wr_cyc; ps0 = n_psr; rf0 = n_rf;
    run_prog(80, cyc);
    ack_dly = 0;
    checks++; if (cyc != 14) begin failures++; $display("FAIL str_cycles got=%0d exp=14", cyc); end
    checks++; if (n_wr - wr0 != 1 || last_waddr !== 12'h040 || last_wsel !== 2'd0) begin
      failures++; $display("FAIL str_write got n=%0d addr=%h wsel=%0d exp 1 040 0", n_wr - wr0, last_waddr, last_wsel); end
    checks++; if (n_wr_cyc - wc0 != 4) begin failures++; $display("FAIL str_hold got=%0d exp=4", n_wr_cyc - wc0); end
    checks++; if (n_psr - ps0 != 1 || last_psr_ack !== 1'b1 || n_rf != rf0) begin
      failures++; $display("FAIL str_strobes got psr=%0d at_ack=%b rf=%0d exp 1/1/0", n_psr - ps0, last_psr_ack, n_rf - rf0); end
  endtask

  task automatic test_alu();
    int cyc, al0, ps0, wr0, rf0;
    mem[6] = 32'h4400_0100;
    mem[7] = HLT;
    alu_dly = 2;
    al0 = n_alu; ps0 = n_psr; wr0 = n_wr; rf0 = n_rf;
    run_prog(30, cyc);
    checks++; if (cyc != 7) begin failures++; $display("FAIL alu_mem_cycles got=%0d exp=7", cyc); end
    checks++; if (n_alu - al0 != 1) begin failures++; $display("FAIL alu_start_count got=%0d exp=1", n_alu - al0); end
    checks++; if (n_psr - ps0 != 1 || last_psr_done !== 1'b1) begin
      failures++; $display("FAIL alu_psr got n=%0d at_done=%b exp 1/1", n_psr - ps0, last_psr_done); end
    checks++; if (n_wr - wr0 != 1 || last_waddr !== 12'h100 || last_wsel !== 2'd2 || n_rf != rf0) begin
      failures++; $display("FAIL alu_wrb got n=%0d addr=%h wsel=%0d rf=%0d exp 1 100 2 0", n_wr - wr0, last_waddr, last_wsel, n_rf - rf0); end
    mem[8] = 32'h5000_0003;
    mem[9] = HLT;
    alu_dly = 1;
    wr0 = n_wr; rf0 = n_rf;
    run_prog(30, cyc);
    checks++; if (cyc != 5) begin failures++; $display("FAIL alu_reg_cycles got=%0d exp=5", cyc); end
    checks++; if (n_rf - rf0 != 1 || n_wr != wr0 || pc !== 12'h00A) begin
      failures++; $display("FAIL alu_reg got rf=%0d wr=%0d pc=%h exp 1/0/00a", n_rf - rf0, n_wr - wr0, pc); end
  endtask

  task automatic test_branch();
    int cyc;
    psr_in = 5'b00000;
    mem[10] = 32'h1400_0020;
    mem[11] = HLT;
    run_prog(20, cyc);
    checks++; if (cyc != 4 || pc !== 12'h00C) begin failures++; $display("FAIL bra_not_taken got cyc=%0d pc=%h exp 4 00c", cyc, pc); end
    psr_in = 5'b01000;
    mem[12] = 32'h1400_0020;
    mem[32] = HLT;
    run_prog(20, cyc);
    checks++; if (pc !== 12'h021) begin failures++; $display("FAIL bra_taken got pc=%h exp=021", pc); end
    psr_in = 5'b11111;
    mem[33] = 32'h1600_0030;
    mem[34] = HLT;
    run_prog(20, cyc);
    checks++; if (pc !== 12'h023) begin failures++; $display("FAIL bra_never got pc=%h exp=023", pc); end
    psr_in = 5'b00000;
    mem[35] = 32'h1000_0FFF;
    mem[4095] = 32'h0000_0000;
    mem[0] = HLT;
    run_prog(20, cyc);
    checks++; if (cyc != 6 || pc !== 12'h001 || rd_prev !== 12'hFFF || rd_last !== 12'h000) begin
      failures++; $display("FAIL pc_wrap got cyc=%0d pc=%h fetch %h,%h exp 6 001 fff,000", cyc, pc, rd_prev, rd_last); end
  endtask

  task automatic test_illegal_reset();
    int cyc;
    mem[1] = 32'hA000_0000;
    mem[2] = 32'h2000_3005;
    stall_addr = 3;
`ifdef RISC_ILLEGAL_HALT_EN
    run_prog(20, cyc);
    checks++; if (cyc != 2 || illegal !== 1'b1) begin
      failures++; $display("FAIL illegal_halt got cyc=%0d illegal=%b exp 2/1", cyc, illegal); end
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(mbus.mem_req && !mbus.mem_we && mbus.mem_addr == 12'h003) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc >= 20) begin failures++; $display("FAIL memrd_reach got timeout exp read of 003"); end
    checks++; if (illegal !== 1'b1 || halted !== 1'b0 || ir !== 32'h2000_3005) begin
      failures++; $display("FAIL illegal_flag got illegal=%b halted=%b ir=%h exp 1/0/20003005", illegal, halted, ir); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mbus.mem_req !== 1'b0) begin failures++; $display("FAIL async_req_drop got=%b exp=0", mbus.mem_req); end
    checks++; if (pc !== '0 || ir !== 32'd0 || illegal !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL async_reset_state got pc=%h ir=%h ill=%b halt=%b exp 0", pc, ir, illegal, halted); end
    stall_addr = -1;
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mbus.mem_req !== 1'b0 || pc !== '0) begin
      failures++; $display("FAIL post_reset_idle got req=%b pc=%h exp 0/000", mbus.mem_req, pc); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    test_reset();
    test_nop_hlt();
    test_ld_imm();
    test_str_delayed();
    test_alu();
    test_branch();
    test_illegal_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
